seq_chunk_adder: RTL and testbench

- Parametrised, multi-cycle add/subtract unit; successor to the 1-bit combinational half adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through one CHUNK-bit adder slice with a registered carry.
- Returns sum, carry-out and signed overflow.
- Valid/ready handshakes on input and output let it sit between registered datapath stages without external sequencing.

---
 rtl/seq_chunk_adder_if.sv | 26 ++
 rtl/seq_chunk_adder.sv | 105 ++++++++++
 tb/tb_seq_chunk_adder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// rtl/seq_chunk_adder_if.sv - operand/result handshake bundle for seq_chunk_adder
interface seq_chunk_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c;
   logic             v;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, c, v
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, c, v
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked add/subtract unit with valid/ready handshakes
module seq_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   seq_chunk_adder_if.slave op_if
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             v_q, v_d;

   // Bit offset of the chunk being processed and the single shared adder slice.
   logic [31:0]      base;
   logic [CHUNK:0]   slice_sum;

   assign base      = 32'(idx_q) * CHUNK;
   assign slice_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_q};

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
         c_q     <= c_d;
         v_q     <= v_d;
      end
   end

   // Next-state logic: accept in IDLE, one chunk per RUN cycle, hold result in DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;
      case (state_q)
         IDLE: begin
            if (op_if.in_valid) begin
               // Subtract is A + ~B + ~borrow, so invert B and the carry-in once here.
               a_d     = op_if.a;
               b_d     = op_if.sub ? ~op_if.b : op_if.b;
               carry_d = op_if.cin ^ op_if.sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
            carry_d            = slice_sum[CHUNK];
            idx_d              = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // The last chunk holds the MSB, so slice_sum[CHUNK-1] is the result sign.
               c_d     = slice_sum[CHUNK];
               v_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (op_if.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign op_if.in_ready  = (state_q == IDLE);
   assign op_if.out_valid = (state_q == DONE);
   assign op_if.s         = s_q;
   assign op_if.c         = c_q;
   assign op_if.v         = v_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - scoreboard bench for seq_chunk_adder at CHUNK=1, 4 and 8
module tb_seq_chunk_adder;
   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       v;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, out_ready, cin, sub;
   logic [7:0] a, b;
   int         sel;
   int         cyc = 0;
   int         acc_cyc;
   int         n_total = 0;
   int         n_pass = 0;
   res_t       sb_q[$];

   logic       m_in_ready, m_out_valid, m_c, m_v;
   logic [7:0] m_s;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_chunk_adder_if #(.WIDTH(8)) if1 ();
   seq_chunk_adder_if #(.WIDTH(8)) if4 ();
   seq_chunk_adder_if #(.WIDTH(8)) if8 ();

   assign if1.in_valid  = in_valid && (sel == 0);
   assign if4.in_valid  = in_valid && (sel == 1);
   assign if8.in_valid  = in_valid && (sel == 2);
   assign if1.out_ready = out_ready && (sel == 0);
   assign if4.out_ready = out_ready && (sel == 1);
   assign if8.out_ready = out_ready && (sel == 2);
   assign if1.a = a;   assign if4.a = a;   assign if8.a = a;
   assign if1.b = b;   assign if4.b = b;   assign if8.b = b;
   assign if1.cin = cin; assign if4.cin = cin; assign if8.cin = cin;
   assign if1.sub = sub; assign if4.sub = sub; assign if8.sub = sub;

   assign m_in_ready  = (sel == 0) ? if1.in_ready  : (sel == 1) ? if4.in_ready  : if8.in_ready;
   assign m_out_valid = (sel == 0) ? if1.out_valid : (sel == 1) ? if4.out_valid : if8.out_valid;
   assign m_s         = (sel == 0) ? if1.s         : (sel == 1) ? if4.s         : if8.s;
   assign m_c         = (sel == 0) ? if1.c         : (sel == 1) ? if4.c         : if8.c;
   assign m_v         = (sel == 0) ? if1.v         : (sel == 1) ? if4.v         : if8.v;

   seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .op_if(if1.slave));
   seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .op_if(if4.slave));
   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (.clk_i(clk), .rst_ni(rst_n), .op_if(if8.slave));

   function automatic int lat_exp(input int s_sel);
      return (s_sel == 0) ? 8 : (s_sel == 1) ? 2 : 1;
   endfunction

   // Reference: plain integer arithmetic, with signed range test for overflow.
   function automatic res_t model(input logic [7:0] a_v, input logic [7:0] b_v,
                                  input logic ci, input logic sb);
      res_t r;
      int   sv;
      if (!sb) begin
         {r.c, r.s} = 9'(a_v) + 9'(b_v) + 9'(ci);
         sv = int'($signed(a_v)) + int'($signed(b_v)) + int'(ci);
      end else begin
         r.s = a_v - b_v - 8'(ci);
         r.c = (int'(a_v) >= int'(b_v) + int'(ci));
         sv  = int'($signed(a_v)) - int'($signed(b_v)) - int'(ci);
      end
      r.v = (sv > 127) || (sv < -128);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                       input logic ci, input logic sb);
      int n = 0;
      a = a_v; b = b_v; cin = ci; sub = sb; in_valid = 1'b1;
      while (!m_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept_timeout"}, 32'(n < 100), 1);
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      sb_q.push_back(model(a_v, b_v, ci, sb));
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
   endtask

   task automatic get_result(input string tag, input int stall);
      res_t e;
      int   n = 0;
      logic rdy_seen = 1'b0;
      @(negedge clk);
      while (!m_out_valid && n < 200) begin
         if (m_in_ready) rdy_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      if (m_in_ready) rdy_seen = 1'b1;
      check({tag, "_out_timeout"}, 32'(n < 200), 1);
      check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(lat_exp(sel)));
      check({tag, "_in_ready_busy"}, 32'(rdy_seen), 0);
      e = sb_q.pop_front();
      for (int k = 0; k < stall; k++) begin
         in_valid = ~in_valid;
         a = 8'($urandom); b = 8'($urandom);
         @(negedge clk);
         check({tag, "_stall_hold"}, {19'd0, m_out_valid, m_in_ready, m_s, m_c, m_v},
               {19'd0, 1'b1, 1'b0, e.s, e.c, e.v});
      end
      in_valid = 1'b0;
      check({tag, "_s"}, 32'(m_s), 32'(e.s));
      check({tag, "_c"}, 32'(m_c), 32'(e.c));
      check({tag, "_v"}, 32'(m_v), 32'(e.v));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_idle_after_hs"}, {30'd0, m_in_ready, m_out_valid}, {30'd0, 1'b1, 1'b0});
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {20'd0, m_out_valid, m_s, m_c, m_v, m_in_ready}, {20'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 32'(m_in_ready), 1);

      // Basic add, CHUNK=1: eight-cycle latency
      send("add0f01", 8'h0F, 8'h01, 1'b0, 1'b0);
      get_result("add0f01", 0);
      send("addff01c", 8'hFF, 8'h01, 1'b1, 1'b0);
      get_result("addff01c", 0);
      send("add7f01", 8'h7F, 8'h01, 1'b0, 1'b0);
      get_result("add7f01", 0);
      send("addffffc", 8'hFF, 8'hFF, 1'b1, 1'b0);
      get_result("addffffc", 0);

      // Subtract cases, including B=0 identity
      send("sub0507", 8'h05, 8'h07, 1'b0, 1'b1);
      get_result("sub0507", 0);
      send("sub8001", 8'h80, 8'h01, 1'b0, 1'b1);
      get_result("sub8001", 0);
      send("sub1003b", 8'h10, 8'h03, 1'b1, 1'b1);
      get_result("sub1003b", 0);
      send("sub5a00", 8'h5A, 8'h00, 1'b0, 1'b1);
      get_result("sub5a00", 0);

      // Backpressure in DONE, then a fresh op
      send("bp", 8'h3C, 8'h41, 1'b0, 1'b0);
      get_result("bp", 5);
      send("bp_next", 8'hA5, 8'h5A, 1'b1, 1'b0);
      get_result("bp_next", 0);

      // Asynchronous reset after three chunks of an eight-chunk op
      send("rst_run", 8'h0F, 8'h01, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_run", {20'd0, m_out_valid, m_s, m_c, m_v, m_in_ready}, {20'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
      void'(sb_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_ready", {30'd0, m_in_ready, m_out_valid}, {30'd0, 1'b1, 1'b0});
      send("after_rst", 8'h22, 8'h11, 1'b0, 1'b0);
      get_result("after_rst", 0);

      // Wider chunks: latency 2 and 1
      sel = 1;
      send("c4_9c6b", 8'h9C, 8'h6B, 1'b0, 1'b0);
      get_result("c4_9c6b", 0);
      sel = 2;
      send("c8_9c6b", 8'h9C, 8'h6B, 1'b0, 1'b0);
      get_result("c8_9c6b", 0);

      // Randomised ops across all three builds with random result stalls
      for (int i = 0; i < 300; i++) begin
         sel = i % 3;
         send("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
         get_result("rnd", int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
